// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detector_param
//  Description : Serial pattern detector. Compares a qualified bit stream
//                against a runtime-loadable SEQ_LEN-bit pattern (MSB first),
//                with run-time selectable overlapping / non-overlapping
//                detection, a registered one-cycle match pulse and an
//                optional saturating match counter.
//  Options     : SEQDET_COUNT_EN - when defined, builds the match counter and
//                its synchronous clear; otherwise o_match_count is tied to 0
//                and i_cnt_clr is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_param #(
   parameter int                 SEQ_LEN       = 3,
   parameter logic [SEQ_LEN-1:0] RESET_PATTERN = 3'b101,
   parameter int                 CNT_W         = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_load_en,
   input  logic [SEQ_LEN-1:0] i_pattern_in,
   input  logic               i_overlap,
   input  logic               i_seq_valid,
   input  logic               i_seq,
   input  logic               i_cnt_clr,
   output logic               o_detected,
   output logic [CNT_W-1:0]   o_match_count
);

   // Fill counter spans 0..SEQ_LEN-1.
   localparam int                FILL_W    = $clog2(SEQ_LEN);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_LEN - 1);

   typedef enum logic [0:0] {
      ST_FILL = 1'b0,   // history not yet holding SEQ_LEN-1 valid bits
      ST_HUNT = 1'b1    // history full, every accepted bit is a candidate
   } state_t;

   state_t               r_state;
   logic [SEQ_LEN-1:0]   r_pat;
   logic [SEQ_LEN-2:0]   r_hist;
   logic [FILL_W-1:0]    r_fill;
   logic                 r_detected;

   logic                 w_accept;
   logic [SEQ_LEN-1:0]   w_cand;
   logic [SEQ_LEN-2:0]   w_hist_next;
   logic [FILL_W-1:0]    w_fill_inc;
   logic                 w_match;

   // A load on the same edge always wins over an arriving bit.
   assign w_accept    = i_seq_valid & ~i_load_en;
   // Candidate window: the stored history followed by the new bit.
   assign w_cand      = {r_hist, i_seq};
   // Dropping the oldest bit of the candidate gives the shifted history;
   // written this way it also covers SEQ_LEN == 2 (single-bit history).
   assign w_hist_next = w_cand[SEQ_LEN-2:0];
   assign w_fill_inc  = r_fill + 1'b1;
   assign w_match     = w_accept & (r_state == ST_HUNT) & (w_cand == r_pat);

   // Pattern/history/fill FSM with registered match pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_FILL;
         r_pat      <= RESET_PATTERN;
         r_hist     <= '0;
         r_fill     <= '0;
         r_detected <= 1'b0;
      end else if (i_load_en) begin
         r_pat      <= i_pattern_in;
         r_fill     <= '0;
         r_state    <= ST_FILL;
         r_detected <= 1'b0;
      end else if (w_accept) begin
         r_detected <= w_match;
         if (w_match && !i_overlap) begin
            // Matched bits are consumed: refill from scratch.
            r_fill  <= '0;
            r_state <= ST_FILL;
         end else begin
            r_hist <= w_hist_next;
            if (r_state == ST_FILL) begin
               r_fill <= w_fill_inc;
               if (w_fill_inc == FILL_FULL) begin
                  r_state <= ST_HUNT;
               end
            end
         end
      end else begin
         r_detected <= 1'b0;
      end
   end

   assign o_detected = r_detected;

`ifdef SEQDET_COUNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] r_count;

   // Saturating match counter; clear has priority over an increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_cnt_clr) begin
         r_count <= '0;
      end else if (w_match && (r_count != CNT_MAX)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_match_count = r_count;
`else
   logic w_unused_cnt_clr;

   assign w_unused_cnt_clr = i_cnt_clr;
   assign o_match_count    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detector_param
//  Description : Self-checking bench for seq_detector_param. Three instances
//                (SEQ_LEN 3 / 4 / 2) are driven with directed vectors; a
//                bit-history model predicts detected/match_count each cycle.
//                Honours SEQDET_COUNT_EN for the expected counter values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

`ifdef SEQDET_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic [2:0] ld, ov, sv, sq, clr;
   logic [2:0] pin0;
   logic [3:0] pin1;
   logic [1:0] pin2;
   logic [2:0] det;
   logic [7:0] cnt0, cnt1;
   logic [1:0] cnt2;

   int n_chk;
   int n_fail;

   // Model state: unbounded record of accepted bits since the last restart.
   logic [31:0] m_hv  [3];
   int          m_nb  [3];
   logic [15:0] m_pat [3];
   logic [2:0]  e_det;
   int          e_cnt [3];

   seq_detector_param #(.SEQ_LEN(3), .RESET_PATTERN(3'b101), .CNT_W(8)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .i_load_en(ld[0]), .i_pattern_in(pin0),
      .i_overlap(ov[0]), .i_seq_valid(sv[0]), .i_seq(sq[0]), .i_cnt_clr(clr[0]),
      .o_detected(det[0]), .o_match_count(cnt0));

   seq_detector_param #(.SEQ_LEN(4), .RESET_PATTERN(4'b1001), .CNT_W(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .i_load_en(ld[1]), .i_pattern_in(pin1),
      .i_overlap(ov[1]), .i_seq_valid(sv[1]), .i_seq(sq[1]), .i_cnt_clr(clr[1]),
      .o_detected(det[1]), .o_match_count(cnt1));

   seq_detector_param #(.SEQ_LEN(2), .RESET_PATTERN(2'b11), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .i_load_en(ld[2]), .i_pattern_in(pin2),
      .i_overlap(ov[2]), .i_seq_valid(sv[2]), .i_seq(sq[2]), .i_cnt_clr(clr[2]),
      .o_detected(det[2]), .o_match_count(cnt2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int len_of(input int i);
      case (i)
         0:       return 3;
         1:       return 4;
         default: return 2;
      endcase
   endfunction

   function automatic int max_of(input int i);
      return (i == 2) ? 3 : 255;
   endfunction

   function automatic logic [15:0] rst_pat_of(input int i);
      case (i)
         0:       return 16'h5;
         1:       return 16'h9;
         default: return 16'h3;
      endcase
   endfunction

   function automatic logic [15:0] pin_of(input int i);
      case (i)
         0:       return {13'd0, pin0};
         1:       return {12'd0, pin1};
         default: return {14'd0, pin2};
      endcase
   endfunction

   function automatic int cnt_of(input int i);
      case (i)
         0:       return int'(cnt0);
         1:       return int'(cnt1);
         default: return int'(cnt2);
      endcase
   endfunction

   task automatic chk(input string nm, input int idx, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, idx, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_hv[i]  = '0;
         m_nb[i]  = 0;
         m_pat[i] = rst_pat_of(i);
         e_det[i] = 1'b0;
         e_cnt[i] = 0;
      end
   endtask

   // Predict the effect of the coming rising edge from the current inputs.
   task automatic model_edge();
      logic [31:0] mask;
      if (!rst_n) begin
         model_reset();
      end else begin
         for (int i = 0; i < 3; i++) begin
            mask = (32'd1 << len_of(i)) - 32'd1;
            if (ld[i]) begin
               m_pat[i] = pin_of(i);
               m_nb[i]  = 0;
               e_det[i] = 1'b0;
            end else if (sv[i]) begin
               m_hv[i]  = {m_hv[i][30:0], sq[i]};
               m_nb[i]  = m_nb[i] + 1;
               e_det[i] = (m_nb[i] >= len_of(i)) && ((m_hv[i] & mask) == {16'd0, m_pat[i]});
               if (e_det[i] && !ov[i]) m_nb[i] = 0;
            end else begin
               e_det[i] = 1'b0;
            end
            if (!CNT_EN)                               e_cnt[i] = 0;
            else if (clr[i])                           e_cnt[i] = 0;
            else if (e_det[i] && e_cnt[i] < max_of(i)) e_cnt[i] = e_cnt[i] + 1;
         end
      end
   endtask

   // Drive one DUT for one cycle (others idle) and advance the model.
   task automatic step(input int i, input bit l, input logic [15:0] p,
                       input bit o, input bit v, input bit s, input bit c);
      @(negedge clk);
      ld  = '0;
      sv  = '0;
      sq  = '0;
      clr = '0;
      ld[i]  = l;
      ov[i]  = o;
      sv[i]  = v;
      sq[i]  = s;
      clr[i] = c;
      case (i)
         0:       pin0 = p[2:0];
         1:       pin1 = p[3:0];
         default: pin2 = p[1:0];
      endcase
      model_edge();
   endtask

   task automatic send(input int i, input bit o, input logic [15:0] bits, input int n);
      for (int k = n - 1; k >= 0; k--) step(i, 1'b0, 16'd0, o, 1'b1, bits[k], 1'b0);
   endtask

   task automatic release_rst();
      @(negedge clk);
      rst_n = 1'b1;
      ld  = '0;
      sv  = '0;
      sq  = '0;
      clr = '0;
      model_edge();
   endtask

   // Observe the edge that samples the last driven inputs.
   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // Every cycle: outputs of all instances against the model.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("detected", i, int'(det[i]), int'(e_det[i]));
         chk("match_count", i, cnt_of(i), e_cnt[i]);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] b1101;
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      ld = '0; ov = '0; sv = '0; sq = '0; clr = '0;
      pin0 = '0; pin1 = '0; pin2 = '0;
      model_reset();

      // Inputs toggling while held in reset must have no effect.
      step(0, 1'b1, 16'h7, 1'b1, 1'b1, 1'b1, 1'b1);
      step(0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0);
      step(0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0);
      settle();
      chk("rst_det", 0, int'(det[0]), 0);
      chk("rst_cnt", 0, int'(cnt0), 0);
      release_rst();

      // Non-overlap, pattern 101: stream 1,0,1,0,1 gives one pulse.
      send(0, 1'b0, 16'b101, 3);
      settle();
      chk("nov_pulse3", 0, int'(det[0]), 1);
      send(0, 1'b0, 16'b01, 2);
      settle();
      chk("nov_nopulse5", 0, int'(det[0]), 0);
      chk("nov_cnt", 0, int'(cnt0), CNT_EN ? 1 : 0);

      // Overlap: restart with a reload + clear, same stream gives two pulses.
      step(0, 1'b1, 16'b101, 1'b1, 1'b0, 1'b0, 1'b1);
      send(0, 1'b1, 16'b10101, 5);
      settle();
      chk("ov_pulse5", 0, int'(det[0]), 1);
      chk("ov_cnt", 0, int'(cnt0), CNT_EN ? 2 : 0);

      // Switch to non-overlap mid-stream: 0,1 completes 101, then 0,1 does not.
      send(0, 1'b0, 16'b01, 2);
      settle();
      chk("sw_pulse", 0, int'(det[0]), 1);
      send(0, 1'b0, 16'b01, 2);
      settle();
      chk("sw_nopulse", 0, int'(det[0]), 0);

      // SEQ_LEN=4: bit on the load edge is not part of the stream.
      step(1, 1'b1, 16'hD, 1'b0, 1'b1, 1'b1, 1'b0);
      send(1, 1'b0, 16'b101, 3);
      settle();
      chk("load_edge_ignored", 1, int'(det[1]), 0);

      // Reload 1101 and send it with two invalid cycles between bits.
      step(1, 1'b1, 16'hD, 1'b0, 1'b0, 1'b0, 1'b0);
      b1101 = 4'b1101;
      for (int k = 3; k >= 0; k--) begin
         step(1, 1'b0, 16'd0, 1'b0, 1'b1, b1101[k], 1'b0);
         if (k != 0) begin
            step(1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            step(1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         end
      end
      settle();
      chk("gap_pulse", 1, int'(det[1]), 1);
      chk("gap_cnt", 1, int'(cnt1), CNT_EN ? 1 : 0);

      // Saturation: CNT_W=2, pattern 11, overlap, six ones -> five pulses.
      step(2, 1'b1, 16'h3, 1'b1, 1'b0, 1'b0, 1'b1);
      send(2, 1'b1, 16'h3F, 6);
      settle();
      chk("sat_pulse", 2, int'(det[2]), 1);
      chk("sat_cnt", 2, int'(cnt2), CNT_EN ? 3 : 0);
      step(2, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1);
      settle();
      chk("clr_pulse", 2, int'(det[2]), 1);
      chk("clr_cnt", 2, int'(cnt2), 0);

      // Asynchronous reset while a pulse is showing clears it at once.
      step(0, 1'b1, 16'b101, 1'b0, 1'b0, 1'b0, 1'b0);
      send(0, 1'b0, 16'b101, 3);
      @(posedge clk);
      #3;
      chk("pre_rst_det", 0, int'(det[0]), 1);
      chk("pre_rst_cnt", 0, int'(cnt0), CNT_EN ? 4 : 0);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_rst_det", 0, int'(det[0]), 0);
      chk("async_rst_cnt", 0, int'(cnt0), 0);
      release_rst();

      // Reset between partial bits discards them.
      send(0, 1'b0, 16'b10, 2);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      model_reset();
      release_rst();
      send(0, 1'b0, 16'b1, 1);
      settle();
      chk("post_rst_nopulse", 0, int'(det[0]), 0);
      send(0, 1'b0, 16'b01, 2);
      settle();
      chk("post_rst_pulse", 0, int'(det[0]), 1);

      step(0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      settle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
